// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Registered instruction-decode stage. Splits the instruction into
//             opcode, one-hot decode, register addresses and a sign-extended
//             immediate; flags illegal opcodes; keeps a per-register busy
//             scoreboard and stalls fetch on read-after-write hazards.
//  Options  : DECODE_WB_BYPASS_EN - a writeback in the current cycle unblocks
//             a dependent instruction with no extra stall cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int INSTRUCTION_WIDTH = 25,
  parameter int WIDTH_OPCODE      = 5,
  parameter int REGFILE_ADDR_BITS = 3,
  parameter int IMMEDIATE_WIDTH   = 12,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_INSTRUCTIONS  = 2**WIDTH_OPCODE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]     in_instruction,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH_OPCODE-1:0]          out_opcode,
  output logic [NUM_INSTRUCTIONS-1:0]      out_decoded,
  output logic [REGFILE_ADDR_BITS-1:0]     out_reg_dest,
  output logic [REGFILE_ADDR_BITS-1:0]     out_reg_source,
  output logic [DATA_WIDTH-1:0]            out_immediate,
  output logic                             out_writes_reg,
  output logic                             out_illegal,
  input  logic                             wb_valid,
  input  logic [REGFILE_ADDR_BITS-1:0]     wb_addr,
  input  logic                             flush,
  output logic [2**REGFILE_ADDR_BITS-1:0]  busy_regs
);

  localparam int c_NUM_REGISTERS = 2**REGFILE_ADDR_BITS;
  localparam int c_OP_LSB        = INSTRUCTION_WIDTH - WIDTH_OPCODE;
  localparam int c_DEST_LSB      = c_OP_LSB - REGFILE_ADDR_BITS;
  localparam int c_SRC_LSB       = c_DEST_LSB - REGFILE_ADDR_BITS;
  localparam int c_UNUSED_BITS   = c_SRC_LSB - IMMEDIATE_WIDTH;

  localparam logic [WIDTH_OPCODE-1:0] c_OP_NOP  = WIDTH_OPCODE'(0);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_ADD  = WIDTH_OPCODE'(1);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_LR   = WIDTH_OPCODE'(2);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_SR   = WIDTH_OPCODE'(3);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_ADDI = WIDTH_OPCODE'(4);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_BEQ  = WIDTH_OPCODE'(5);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_J    = WIDTH_OPCODE'(6);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_SUB  = WIDTH_OPCODE'(7);

  localparam logic [c_NUM_REGISTERS-1:0]  c_ONE_REG   = c_NUM_REGISTERS'(1);
  localparam logic [NUM_INSTRUCTIONS-1:0] c_ONE_INSTR = NUM_INSTRUCTIONS'(1);

  // Field layout must fit inside the instruction word.
  if (WIDTH_OPCODE + 2*REGFILE_ADDR_BITS + IMMEDIATE_WIDTH > INSTRUCTION_WIDTH) begin : g_width_check
    $error("decode_stage: instruction fields exceed INSTRUCTION_WIDTH");
  end

  // Bits between the source field and the immediate carry no meaning.
  if (c_UNUSED_BITS > 0) begin : g_unused_field
    logic w_unused_bits;
    assign w_unused_bits = ^in_instruction[c_SRC_LSB-1:IMMEDIATE_WIDTH];
  end

  // Field extraction
  logic [WIDTH_OPCODE-1:0]      w_opcode;
  logic [REGFILE_ADDR_BITS-1:0] w_dest;
  logic [REGFILE_ADDR_BITS-1:0] w_source;
  logic [IMMEDIATE_WIDTH-1:0]   w_imm;

  assign w_opcode = in_instruction[INSTRUCTION_WIDTH-1:c_OP_LSB];
  assign w_dest   = in_instruction[c_OP_LSB-1:c_DEST_LSB];
  assign w_source = in_instruction[c_DEST_LSB-1:c_SRC_LSB];
  assign w_imm    = in_instruction[IMMEDIATE_WIDTH-1:0];

  logic w_reads_dest;
  logic w_reads_src;
  logic w_writes;
  logic w_illegal;

  // Per-opcode register usage and legality.
  always_comb begin
    w_reads_dest = 1'b0;
    w_reads_src  = 1'b0;
    w_writes     = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      c_OP_NOP, c_OP_J: ;
      c_OP_ADD, c_OP_SUB: begin
        w_reads_dest = 1'b1;
        w_reads_src  = 1'b1;
        w_writes     = 1'b1;
      end
      c_OP_LR: begin
        w_reads_src = 1'b1;
        w_writes    = 1'b1;
      end
      c_OP_SR, c_OP_BEQ: begin
        w_reads_dest = 1'b1;
        w_reads_src  = 1'b1;
      end
      c_OP_ADDI: begin
        w_reads_dest = 1'b1;
        w_writes     = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  logic [c_NUM_REGISTERS-1:0]  r_busy;
  logic [c_NUM_REGISTERS-1:0]  w_wb_onehot;
  logic [c_NUM_REGISTERS-1:0]  w_busy_eff;
  logic [c_NUM_REGISTERS-1:0]  w_set;
  logic [c_NUM_REGISTERS-1:0]  w_busy_next;
  logic                        w_hazard;
  logic                        w_accept;

  assign w_wb_onehot = (wb_valid && (wb_addr != '0)) ? (c_ONE_REG << wb_addr) : '0;

`ifdef DECODE_WB_BYPASS_EN
  // A register retiring this cycle is already treated as free.
  assign w_busy_eff = r_busy & ~w_wb_onehot;
`else
  assign w_busy_eff = r_busy;
`endif

  // R0 is hard-wired to zero, so it never creates a dependency.
  assign w_hazard = in_valid &&
                    ((w_reads_dest && (w_dest   != '0) && w_busy_eff[w_dest]) ||
                     (w_reads_src  && (w_source != '0) && w_busy_eff[w_source]));

  assign in_ready = (!out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  // Issued writers mark their destination busy; a same-cycle set beats a clear.
  assign w_set = (out_valid && out_ready && out_writes_reg && !flush) ?
                 (c_ONE_REG << out_reg_dest) : '0;
  assign w_busy_next = ((r_busy & ~w_wb_onehot) | w_set) & ~c_ONE_REG;

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  assign busy_regs = r_busy;

  logic                         r_valid;
  logic [WIDTH_OPCODE-1:0]      r_opcode;
  logic [NUM_INSTRUCTIONS-1:0]  r_decoded;
  logic [REGFILE_ADDR_BITS-1:0] r_dest;
  logic [REGFILE_ADDR_BITS-1:0] r_source;
  logic [DATA_WIDTH-1:0]        r_imm;
  logic                         r_writes;
  logic                         r_illegal;

  // Output register: flush drops, accept loads, handshake without accept drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_decoded <= '0;
      r_dest    <= '0;
      r_source  <= '0;
      r_imm     <= '0;
      r_writes  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_opcode  <= w_opcode;
      r_decoded <= w_illegal ? '0 : (c_ONE_INSTR << w_opcode);
      r_dest    <= w_dest;
      r_source  <= w_source;
      r_imm     <= {{(DATA_WIDTH-IMMEDIATE_WIDTH){w_imm[IMMEDIATE_WIDTH-1]}}, w_imm};
      r_writes  <= w_writes && (w_dest != '0);
      r_illegal <= w_illegal;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_opcode     = r_opcode;
  assign out_decoded    = r_decoded;
  assign out_reg_dest   = r_dest;
  assign out_reg_source = r_source;
  assign out_immediate  = r_imm;
  assign out_writes_reg = r_writes;
  assign out_illegal    = r_illegal;

endmodule
`default_nettype wire
